// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID stage: MIPS field positions, the NOP default,
// the held {instr, pc} entry type and the PC increment helper.
package if_id_pkg;

    localparam int DATA_W = 32;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JADDR_MSB  = 25;
    localparam int JADDR_LSB  = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    // Wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_skid_buf.sv
// Two-entry (main + skid) valid/ready buffer of if_id_t with flush; in_ready is registered.
module if_id_skid_buf
    import if_id_pkg::*;
#(
    parameter if_id_t RESET_DATA = '0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  if_id_t flush_data,
    input  logic   in_valid,
    output logic   in_ready,
    input  if_id_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output if_id_t out_data
);

    logic   main_valid_r, skid_valid_r, in_ready_r;
    if_id_t main_data_r, skid_data_r;
    logic   main_valid_s, skid_valid_s;
    if_id_t main_data_s, skid_data_s;
    logic   accept_s, pop_s;

    // Next-state for both entries; accept implies the skid is empty.
    always_comb begin
        accept_s     = in_valid & in_ready_r;
        pop_s        = main_valid_r & out_ready;
        main_valid_s = main_valid_r;
        skid_valid_s = skid_valid_r;
        main_data_s  = main_data_r;
        skid_data_s  = skid_data_r;
        if (flush) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
            main_data_s  = flush_data;
        end else if (pop_s && skid_valid_r) begin
            main_data_s  = skid_data_r;
            skid_valid_s = 1'b0;
        end else if (accept_s && (pop_s || !main_valid_r)) begin
            main_valid_s = 1'b1;
            main_data_s  = in_data;
        end else if (accept_s) begin
            skid_valid_s = 1'b1;
            skid_data_s  = in_data;
        end else if (pop_s) begin
            main_valid_s = 1'b0;
        end else begin
            main_valid_s = main_valid_r;
        end
    end

    // Entry and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            main_data_r  <= RESET_DATA;
            skid_data_r  <= RESET_DATA;
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= ~skid_valid_s;
            main_data_r  <= main_data_s;
            skid_data_r  <= skid_data_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with MIPS field split and flush.
// Define IF_ID_SKID_EN for a 2-entry skid buffer with registered in_ready.
module if_id_stage
    import if_id_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_pc_plus4,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [15:0]       out_imm16,
    output logic [25:0]       out_jaddr
);

    localparam if_id_t RESET_DATA = '{instr: NOP_INSTR, pc: 32'h0000_0000};

    if_id_t held_s;
    logic   valid_s;
    if_id_t in_data_s;

    assign in_data_s = '{instr: in_instr, pc: in_pc};

`ifdef IF_ID_SKID_EN
    if_id_t flush_data_s;

    assign flush_data_s = '{instr: NOP_INSTR, pc: held_s.pc};

    if_id_skid_buf #(
        .RESET_DATA (RESET_DATA)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .flush_data (flush_data_s),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data_s),
        .out_valid  (valid_s),
        .out_ready  (out_ready),
        .out_data   (held_s)
    );
`else
    logic   valid_r, valid_n_s;
    if_id_t held_r, held_n_s;

    assign in_ready = ~valid_r | out_ready;

    // Next-state: flush beats accept, accept beats drain.
    always_comb begin
        valid_n_s = valid_r;
        held_n_s  = held_r;
        if (flush) begin
            valid_n_s      = 1'b0;
            held_n_s.instr = NOP_INSTR;
        end else if (in_valid && in_ready) begin
            valid_n_s = 1'b1;
            held_n_s  = in_data_s;
        end else if (valid_r && out_ready) begin
            valid_n_s = 1'b0;
        end else begin
            valid_n_s = valid_r;
        end
    end

    // Single holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            held_r  <= RESET_DATA;
        end else begin
            valid_r <= valid_n_s;
            held_r  <= held_n_s;
        end
    end

    assign valid_s = valid_r;
    assign held_s  = held_r;
`endif

    assign out_valid    = valid_s;
    assign out_pc       = held_s.pc;
    assign out_pc_plus4 = pc_plus4(held_s.pc);
    assign out_opcode   = held_s.instr[OPCODE_MSB:OPCODE_LSB];
    assign out_rs       = held_s.instr[RS_MSB:RS_LSB];
    assign out_rt       = held_s.instr[RT_MSB:RT_LSB];
    assign out_rd       = held_s.instr[RD_MSB:RD_LSB];
    assign out_shamt    = held_s.instr[SHAMT_MSB:SHAMT_LSB];
    assign out_funct    = held_s.instr[FUNCT_MSB:FUNCT_LSB];
    assign out_imm16    = held_s.instr[IMM_MSB:IMM_LSB];
    assign out_jaddr    = held_s.instr[JADDR_MSB:JADDR_LSB];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage (both single-entry and IF_ID_SKID_EN builds).
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_pc_plus4;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [15:0] out_imm16;
    logic [25:0] out_jaddr;
    logic        skid_mode;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
        .out_jaddr(out_jaddr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
`ifdef IF_ID_SKID_EN
        skid_mode = 1'b1;
`else
        skid_mode = 1'b0;
`endif
        rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0000_0000, 32'h0000_0000);

        // Reset asserted mid-cycle, checked before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_opcode", 32'(out_opcode), 32'h0);
        check("rst_pc4", out_pc_plus4, 32'h0000_0004);
        step();
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // Streaming.
        out_ready = 1'b1;
        drive(1'b1, 32'h8C22_0010, 32'h0040_0000);
        step();
        check("lw_valid", 32'(out_valid), 32'h1);
        check("lw_opcode", 32'(out_opcode), 32'h23);
        check("lw_rs", 32'(out_rs), 32'h1);
        check("lw_rt", 32'(out_rt), 32'h2);
        check("lw_imm", 32'(out_imm16), 32'h0010);
        check("lw_pc4", out_pc_plus4, 32'h0040_0004);
        drive(1'b1, 32'h0043_2020, 32'h0040_0004);
        step();
        check("add_valid", 32'(out_valid), 32'h1);
        check("add_pc", out_pc, 32'h0040_0004);
        check("add_rs", 32'(out_rs), 32'h2);
        check("add_rt", 32'(out_rt), 32'h3);
        check("add_rd", 32'(out_rd), 32'h4);
        check("add_funct", 32'(out_funct), 32'h20);
        drive(1'b1, 32'h0002_1080, 32'h0040_0008);
        step();
        check("sll_valid", 32'(out_valid), 32'h1);
        check("sll_shamt", 32'(out_shamt), 32'h2);
        check("sll_rd", 32'(out_rd), 32'h2);
        drive(1'b0, 32'h0000_0000, 32'h0000_0000);
        step();
        check("drain_valid", 32'(out_valid), 32'h0);

        // Stall: out_ready low for three cycles while instructions are offered.
        out_ready = 1'b0;
        drive(1'b1, 32'h2401_0001, 32'h0000_0100);
        step();
        check("st1_pc", out_pc, 32'h0000_0100);
        check("st1_in_ready", 32'(in_ready), 32'(skid_mode));
        drive(1'b1, 32'h2402_0002, 32'h0000_0104);
        step();
        check("st2_pc", out_pc, 32'h0000_0100);
        check("st2_in_ready", 32'(in_ready), 32'h0);
        if (skid_mode) drive(1'b1, 32'h2403_0003, 32'h0000_0108);
        step();
        check("st3_pc", out_pc, 32'h0000_0100);
        check("st3_imm", 32'(out_imm16), 32'h0001);
        check("st3_in_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'(!skid_mode));
        step();
        check("rel1_pc", out_pc, 32'h0000_0104);
        check("rel1_imm", 32'(out_imm16), 32'h0002);
        check("rel1_in_ready", 32'(in_ready), 32'h1);
        drive(1'b1, 32'h2403_0003, 32'h0000_0108);
        step();
        check("rel2_pc", out_pc, 32'h0000_0108);
        check("rel2_imm", 32'(out_imm16), 32'h0003);
        drive(1'b0, 32'h0000_0000, 32'h0000_0000);
        step();
        check("rel3_valid", 32'(out_valid), 32'h0);

        // Flush while full with an incoming instruction that must be dropped.
        out_ready = 1'b0;
        drive(1'b1, 32'h3C01_ABCD, 32'h0000_0200);
        step();
        check("fl_full", 32'(out_valid), 32'h1);
        drive(1'b1, 32'h1000_FFFF, 32'h0000_0204);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0000_0000, 32'h0000_0000);
        check("fl_valid", 32'(out_valid), 32'h0);
        check("fl_opcode", 32'(out_opcode), 32'h0);
        check("fl_imm", 32'(out_imm16), 32'h0);
        check("fl_pc_kept", out_pc, 32'h0000_0200);
        check("fl_in_ready", 32'(in_ready), 32'h1);
        step();
        check("fl2_valid", 32'(out_valid), 32'h0);
        check("fl2_imm", 32'(out_imm16), 32'h0);

        // PC wrap plus negative immediate, held with out_ready low.
        out_ready = 1'b0;
        drive(1'b1, 32'h2008_FFFE, 32'hFFFF_FFFC);
        step();
        check("wr_valid", 32'(out_valid), 32'h1);
        check("wr_pc4", out_pc_plus4, 32'h0000_0000);
        check("neg_opcode", 32'(out_opcode), 32'h08);
        check("neg_rt", 32'(out_rt), 32'h8);
        check("neg_imm", 32'(out_imm16), 32'hFFFE);
        check("neg_jaddr", 32'(out_jaddr), 32'h008_FFFE);
        check("neg_sext", {{16{out_imm16[15]}}, out_imm16}, 32'hFFFF_FFFE);

        // X on the input while not ready must leave state untouched.
        if (skid_mode) begin
            drive(1'b1, 32'h0000_0000, 32'h0000_0000);
            step();
        end
        check("x_in_ready", 32'(in_ready), 32'h0);
        drive(1'b1, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        step();
        step();
        check("x_valid", 32'(out_valid), 32'h1);
        check("x_opcode", 32'(out_opcode), 32'h08);
        check("x_imm", 32'(out_imm16), 32'hFFFE);
        check("x_pc", out_pc, 32'hFFFF_FFFC);

        // Reset mid-operation takes effect without a clock edge.
        drive(1'b0, 32'h0000_0000, 32'h0000_0000);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'h0);
        check("mrst_opcode", 32'(out_opcode), 32'h0);
        check("mrst_pc", out_pc, 32'h0000_0000);
        check("mrst_pc4", out_pc_plus4, 32'h0000_0004);
        #2 rst_n = 1'b1;
        step();
        check("mrst_in_ready", 32'(in_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline stage between instruction fetch and decode/execute.
- Registers the fetched instruction and PC, then splits the instruction into MIPS-style fields.
- Its out_imm16 drives the 16-bit input of the downstream immediate sign extender.
- Valid/ready handshake on both sides, plus a flush input for branch/jump redirects.

Parameters:
- DATA_W, 32, instruction and PC width. Must be 32; fields are fixed MIPS positions.
- NOP_INSTR, 32'h0000_0000, value held in the instruction register after reset or flush.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  fetched instruction
- in_pc  in  32  address of in_instr
- flush  in  1  discard all held/incoming instructions
- out_valid  out  1  decoded instruction available
- out_ready  in  1  downstream consumes
- out_pc  out  32  PC of held instruction
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32
- out_opcode  out  6  instr[31:26]
- out_rs  out  5  instr[25:21]
- out_rt  out  5  instr[20:16]
- out_rd  out  5  instr[15:11]
- out_shamt  out  5  instr[10:6]
- out_funct  out  6  instr[5:0]
- out_imm16  out  16  instr[15:0]; goes to the sign extender
- out_jaddr  out  26  instr[25:0]

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values: out_valid=0, held instr=NOP_INSTR, held pc=0.
  - All field outputs therefore decode NOP_INSTR; out_pc_plus4=4.
  - in_ready=1 as soon as reset deasserts.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Latency: 1 cycle. A transfer at edge N gives out_valid=1 after edge N.
- Field decode:
  - Fields are pure slices of the held instruction register.
  - out_pc_plus4 is combinational from held pc and wraps 32'hFFFF_FFFC -> 0.
  - Fields are stable while out_valid=1 and out_ready=0; no change is allowed under stall.
- Simultaneous in/out transfer with the stage full: the new instruction replaces the old one, giving full throughput of 1 instruction per cycle.
- Flush has priority over everything:
  - At the flush edge, out_valid and all internal valid bits clear, and held instr is set to NOP_INSTR.
  - Any input presented that cycle is dropped, even if in_ready=1.
  - Held pc is unchanged.
  - The stage accepts again the cycle after flush.
- Stall: with out_valid=1 and out_ready=0, the held contents are frozen. See Optional Feature for in_ready in this case.
- Reset mid-operation: everything returns to reset values immediately, without waiting for a clock edge.
- in_valid with X on in_instr while in_ready=0 must not affect state.

Optional Feature:
- Macro: IF_ID_SKID_EN
- Defined:
  - Adds a 1-entry skid register, so there are 2 entries in total.
  - in_ready is a registered output, equal to ~skid_valid.
  - Accepting while main is full and out_ready=0 loads the skid register.
  - On the next output transfer the skid entry moves to main; in_ready rises the following cycle.
  - Ordering is strictly FIFO.
  - Flush clears both entries.
- Undefined:
  - Single entry.
  - in_ready = ~out_valid | out_ready, combinational. This is a timing path from out_ready to in_ready, which the team accepts in this mode.

Decomposition:
- Package if_id_pkg holds:
  - Field bit positions and widths (OPCODE_MSB/LSB, RS_*, RT_*, RD_*, SHAMT_*, FUNCT_*, IMM_*, JADDR_*).
  - The NOP_INSTR default.
  - A packed struct type for {instr, pc}.
- Sub-module if_id_skid_buf: a generic 2-entry valid/ready buffer of that struct with a flush input. It is instantiated only under IF_ID_SKID_EN; otherwise a single register is inline.

Test Plan:
- Reset: assert rst_n=0 mid-cycle.
  - Required: out_valid=0 immediately, out_opcode=0, out_pc_plus4=32'h4.
  - After release: in_ready=1.
- Streaming: in_instr=32'h8C22_0010 at pc=32'h0040_0000, out_ready=1.
  - Required next cycle: out_opcode=6'h23, out_rs=1, out_rt=2, out_imm16=16'h0010, out_pc_plus4=32'h0040_0004.
  - Back-to-back inputs keep out_valid=1 every cycle.
- Stall: hold out_ready=0 for 3 cycles while feeding 3 instructions.
  - Outputs stay frozen throughout.
  - Without the macro: in_ready=0 after the first accept.
  - With the macro: exactly 2 accepted, then in_ready=0. Release yields outputs in order.
- Flush: assert flush while the stage is full and in_valid=1 with 32'h1000_FFFF.
  - Required next cycle: out_valid=0, out_instr decodes NOP, and 32'h1000_FFFF never appears at the output.
- Wrap: accept an instruction at pc=32'hFFFF_FFFC.
  - Required: out_pc_plus4=32'h0000_0000.
- Negative immediate: in_instr=32'h2008_FFFE.
  - Required: out_imm16=16'hFFFE and out_jaddr=26'h008_FFFE.
  - The sign extender output must read 32'hFFFF_FFFE.
